// File: rtl/scoreboard_register_file.sv
// Register file with per-register pending-write counters for decode-stage hazard tracking.
// Latency: reads, readReady and rsvAccept are combinational; writes and counters update 1 cycle later.
// Backpressure: rsvAccept drops on flush or a saturated counter; decode stalls while rsvEn && !rsvAccept.
module scoreboard_register_file #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int IDX_W    = 5,
   parameter int NUM_READ = 2,
   parameter int PEND_W   = 2,
   parameter int BYPASS   = 1
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic [NUM_READ*IDX_W-1:0]    readIndex,
   output logic [NUM_READ*DATA_W-1:0]   readData,
   output logic [NUM_READ-1:0]          readReady,
   input  logic                         wbEn,
   input  logic [IDX_W-1:0]             wbIndex,
   input  logic [DATA_W-1:0]            wbData,
   input  logic                         rsvEn,
   input  logic [IDX_W-1:0]             rsvIndex,
   output logic                         rsvAccept,
   input  logic                         flush,
   output logic                         errUnderflow
);

   localparam logic [PEND_W-1:0] CNT_MAX = '1;
   localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [PEND_W-1:0] cnt  [NUM_REGS];
   logic              err_q;
   logic              wb_frees_rsv;

   assign errUnderflow = err_q;

   // Reservation is refused on flush, or when the destination counter is full
   // and no same-cycle writeback to it frees a slot.
   always_comb begin
      wb_frees_rsv = wbEn && (wbIndex == rsvIndex);
      rsvAccept    = rsvEn && !flush && !((cnt[rsvIndex] == CNT_MAX) && !wb_frees_rsv);
   end

   // Per-port read path; register 0 reads as zero because it is never written
   // and its counter never leaves zero.
   for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
      logic [IDX_W-1:0] idx;
      logic             hit;
      assign idx = readIndex[p*IDX_W +: IDX_W];
      assign hit = (BYPASS != 0) && wbEn && (wbIndex == idx) && (idx != '0);
      assign readData[p*DATA_W +: DATA_W] = hit ? wbData : regs[idx];
      assign readReady[p] = (cnt[idx] == '0) || (hit && (cnt[idx] == CNT_ONE));
   end

   // Register storage; writes to index 0 are dropped, flush does not block writes.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      end else if (wbEn && (wbIndex != '0)) begin
         regs[wbIndex] <= wbData;
      end
   end

   // Pending-write counters: reservation increments, writeback decrements,
   // both together cancel; flush clears everything.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      end else if (flush) begin
         for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if ((rsvAccept && (rsvIndex == IDX_W'(r))) &&
                !(wbEn && (wbIndex == IDX_W'(r)) && (cnt[r] != '0)))
               cnt[r] <= cnt[r] + CNT_ONE;
            else if (!(rsvAccept && (rsvIndex == IDX_W'(r))) &&
                     (wbEn && (wbIndex == IDX_W'(r)) && (cnt[r] != '0)))
               cnt[r] <= cnt[r] - CNT_ONE;
         end
      end
   end

   // Sticky flag for a writeback that had no matching reservation.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         err_q <= 1'b0;
      else if (wbEn && (wbIndex != '0) && (cnt[wbIndex] == '0) && !flush)
         err_q <= 1'b1;
   end

endmodule

// File: doc/scoreboard_register_file.md
Name: scoreboard_register_file

Overview:
- Parametrised successor to the decode-stage register file: N read ports, one writeback port, one destination-reservation port.
- Per-register pending-write counters (not single flags), so multiple in-flight writes to the same register (WAW) are tracked correctly.
- Optional writeback-to-read bypass.
- Sits between decode (reads, reservation) and writeback; readReady feeds the hazard/stall unit.

Parameters:
- DATA_W, 32, register data width.
- NUM_REGS, 32, number of architectural registers (power of two, >=2); index 0 hardwired to zero.
- IDX_W, 5, index width = log2(NUM_REGS).
- NUM_READ, 2, number of read ports (1..4).
- PEND_W, 2, pending-counter width; max outstanding writes per register = 2^PEND_W-1.
- BYPASS, 1, 1 = same-cycle writeback data forwarded to reads; 0 = no forwarding.

Ports:
- clk  in  1  rising-edge clock.
- resetN  in  1  asynchronous active-low reset.
- readIndex  in  NUM_READ*IDX_W  packed read indices, port p at [p*IDX_W +: IDX_W].
- readData  out  NUM_READ*DATA_W  packed read data, combinational.
- readReady  out  NUM_READ  1 = port p data is final (no older write outstanding).
- wbEn  in  1  writeback valid.
- wbIndex  in  IDX_W  writeback destination.
- wbData  in  DATA_W  writeback value.
- rsvEn  in  1  decode requests reservation of a destination.
- rsvIndex  in  IDX_W  destination to reserve.
- rsvAccept  out  1  reservation accepted this cycle, combinational.
- flush  in  1  synchronous clear of all pending counters (pipeline squash).
- errUnderflow  out  1  sticky: writeback arrived for a register with count 0.

Behaviour:
- Reset (resetN low, async):
  - All registers = 0, all counters = 0, errUnderflow = 0.
  - Consequently readData = 0, readReady = all 1s, rsvAccept = rsvEn.
- Storage: DATA_W x NUM_REGS array, written on posedge when wbEn && wbIndex != 0. Write latency 1 cycle.
- Register 0:
  - Reads return 0; readReady = 1.
  - Writes are dropped; reservations are accepted but leave no count; writebacks to reg 0 never set errUnderflow.
- Read data, per port p, idx = readIndex[p]:
  - If BYPASS && wbEn && wbIndex == idx && idx != 0: readData = wbData.
  - Otherwise readData = regs[idx].
- Read ready, per port p:
  - readReady[p] = 1 if count[idx] == 0.
  - Also 1 if BYPASS && count[idx] == 1 && wbEn && wbIndex == idx (the last outstanding write is bypassed).
  - 0 otherwise.
- Counter update per register r, at posedge:
  - inc = rsvAccept && rsvIndex == r && r != 0.
  - dec = wbEn && wbIndex == r && count[r] != 0.
  - inc && !dec: +1. dec && !inc: -1. Both: unchanged. Neither: unchanged.
- rsvAccept:
  - = rsvEn && !flush && !(count[rsvIndex] == max && !(wbEn && wbIndex == rsvIndex)).
  - Saturated count is rejected unless a same-cycle writeback frees a slot.
  - Decode must stall while rsvEn && !rsvAccept.
- errUnderflow: set at posedge when wbEn && wbIndex != 0 && count[wbIndex] == 0 && !flush. Data is still written; the counter stays 0. Cleared only by reset.
- Flush (highest priority):
  - At posedge all counters go to 0.
  - Same-cycle reservation is rejected (rsvAccept = 0).
  - Same-cycle writeback still writes data but does not decrement or flag underflow.
  - Register contents are unaffected.
- Multiple read ports may address the same register; each sees identical data/ready.
- Reset asserted mid-operation aborts all pending state immediately; no writeback completes after the reset edge.

Test Plan:
- Reset then read all indices on both ports -> readData = 0, readReady = 2'b11, errUnderflow = 0.
- Write 0x0000_00AA to r3 (rsv then wb 3 cycles later), read r3 on port0 during the wb cycle -> BYPASS=1: readData = 0xAA, readReady[0] = 1 in that cycle; BYPASS=0: readReady[0] = 0, data 0xAA the next cycle.
- Reserve r5 three times (PEND_W=2) -> count 3, fourth rsvEn gives rsvAccept = 0; fourth rsvEn concurrent with wb to r5 -> rsvAccept = 1, count stays 3; three more wbs -> readReady = 1 after the last.
- wbEn to r7 with count 0, wbData = 0x1234 -> r7 = 0x1234, errUnderflow = 1 and stays 1 until resetN low.
- Reserve r2 and r4, assert flush with a concurrent rsvEn r6 and wb r2 = 0x55 -> rsvAccept = 0, all counts 0, r2 = 0x55, errUnderflow = 0, r2/r4/r6 read ready next cycle.
- Write 0xFFFF_FFFF to r0, reserve r0 -> reads of r0 return 0 with readReady = 1; drop resetN mid-burst -> outputs return to reset values asynchronously.
